// File: rtl/store_buffer_if.sv
// store_buffer_if: core store/load handshake and data-memory port of the store buffer.
interface store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic                    st_valid;
    logic                    st_ready;
    logic [ADDR_W-1:0]       st_addr;
    logic [DATA_W-1:0]       st_data;
    logic                    ld_valid;
    logic [ADDR_W-1:0]       ld_addr;
    logic [DATA_W-1:0]       ld_data;
    logic                    ld_fwd;
    logic [ADDR_W-1:0]       dm_address;
    logic [DATA_W-1:0]       dm_data_write;
    logic                    dm_write_enable;
    logic [DATA_W-1:0]       dm_data_read;
    logic                    empty;
    logic [$clog2(DEPTH):0]  count;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr, dm_data_read,
        output st_ready, ld_data, ld_fwd, dm_address, dm_data_write, dm_write_enable, empty, count
    );
    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr, dm_data_read,
        input  st_ready, ld_data, ld_fwd, dm_address, dm_data_write, dm_write_enable, empty, count
    );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: FIFO store queue draining to data memory, loads take priority and forward from the youngest match.
// Optional STB_COALESCE_EN: merge a store into the youngest entry when the address matches and it is not draining.
module store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [PW-1:0]     head, tail, last, widx, idx;
    logic [CW-1:0]     cnt;
    logic              drain, full, merge, wr, enq, hit;
    logic [DATA_W-1:0] fwd_data;

    assign last  = tail - 1'b1;
    assign drain = (cnt != '0) && !bus.ld_valid;
    assign full  = cnt == CW'(DEPTH);
`ifdef STB_COALESCE_EN
    // tail-1 is the draining entry only when it is the sole entry
    assign merge = bus.st_valid && valid[last] && (addr_q[last] == bus.st_addr) && !(drain && cnt == CW'(1));
`else
    assign merge = 1'b0;
`endif
    assign bus.st_ready = !full || merge;
    assign wr   = bus.st_valid && bus.st_ready;
    assign enq  = wr && !merge;
    assign widx = merge ? last : tail;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            cnt   <= '0;
            valid <= '0;
        end else begin
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= tail + 1'b1;
            end
            if (drain) begin
                valid[head] <= 1'b0;
                head        <= head + 1'b1;
            end
            cnt <= cnt + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            addr_q[widx] <= bus.st_addr;
            data_q[widx] <= bus.st_data;
        end
    end

    // walk oldest to youngest so the last hit is the youngest match
    always_comb begin
        hit      = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (valid[idx] && addr_q[idx] == bus.ld_addr) begin
                hit      = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end

    assign bus.ld_fwd          = bus.ld_valid && hit;
    assign bus.ld_data         = bus.ld_fwd ? fwd_data : bus.dm_data_read;
    assign bus.dm_write_enable = drain;
    assign bus.dm_address      = drain ? addr_q[head] : bus.ld_valid ? bus.ld_addr : '0;
    assign bus.dm_data_write   = drain ? data_q[head] : '0;
    assign bus.empty           = cnt == '0;
    assign bus.count           = cnt;
endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: queue-based reference model with per-cycle compare plus directed literal checks.
module tb_store_buffer;
    localparam int DEPTH = 4, AW = 12, DW = 64;
    typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    ent_t q[$];
    ent_t wlog[$];
    logic [DW-1:0] mem [512];

    store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) bus();
    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    assign bus.dm_data_read = mem[bus.dm_address[8:0]];
    always @(posedge clk) if (bus.dm_write_enable) mem[bus.dm_address[8:0]] <= bus.dm_data_write;

    task automatic chk(input string n, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    function automatic bit can_merge();
`ifdef STB_COALESCE_EN
        return q.size() != 0 && q[$].a == bus.st_addr && !(q.size() == 1 && !bus.ld_valid);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        bit m, rdy;
        if (!rst_n) q.delete();
        else begin
            m   = can_merge();
            rdy = q.size() != DEPTH || m;
            if (q.size() != 0 && !bus.ld_valid) void'(q.pop_front());
            if (bus.st_valid && rdy) begin
                if (m) q[$].d = bus.st_data;
                else q.push_back(ent_t'{a: bus.st_addr, d: bus.st_data});
            end
        end
    end

    always @(negedge clk) begin
        bit we, hit;
        logic [DW-1:0] fd;
        if (rst_n) begin
            we = q.size() != 0 && !bus.ld_valid;
            chk("count", 64'(bus.count), 64'(q.size()));
            chk("empty", 64'(bus.empty), 64'(q.size() == 0));
            chk("st_ready", 64'(bus.st_ready), 64'(q.size() != DEPTH || can_merge()));
            chk("dm_write_enable", 64'(bus.dm_write_enable), 64'(we));
            chk("dm_address", 64'(bus.dm_address), 64'(we ? q[0].a : bus.ld_valid ? bus.ld_addr : 12'h000));
            chk("dm_data_write", bus.dm_data_write, we ? q[0].d : 64'h0);
            if (bus.ld_valid) begin
                hit = 1'b0;
                fd  = bus.dm_data_read;
                foreach (q[i]) if (q[i].a == bus.ld_addr) begin
                    hit = 1'b1;
                    fd  = q[i].d;
                end
                chk("ld_fwd", 64'(bus.ld_fwd), 64'(hit));
                chk("ld_data", bus.ld_data, fd);
            end
            if (bus.dm_write_enable) wlog.push_back(ent_t'{a: bus.dm_address, d: bus.dm_data_write});
        end
    end

    task automatic put(input logic sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                       input logic lv, input logic [AW-1:0] la);
        bus.st_valid = sv;
        bus.st_addr  = sa;
        bus.st_data  = sd;
        bus.ld_valid = lv;
        bus.ld_addr  = la;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'hA5A5_0000_0000_0000 | 64'(i);
        put(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        // reset mid-operation with entries pending
        put(1, 12'h040, 64'h1, 1, 12'h100);
        tick();
        tick();
        chk("pre_reset_count", 64'(bus.count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_count", 64'(bus.count), 64'd0);
        chk("rst_empty", 64'(bus.empty), 64'd1);
        chk("rst_st_ready", 64'(bus.st_ready), 64'd1);
        chk("rst_dm_we", 64'(bus.dm_write_enable), 64'd0);
        put(0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        // store then drain
        put(1, 12'h005, 64'hDEAD_BEEF_0000_0001, 0, 0);
        tick();
        put(0, 0, 0, 0, 0);
        #1;
        chk("drain_we", 64'(bus.dm_write_enable), 64'd1);
        chk("drain_addr", 64'(bus.dm_address), 64'h005);
        chk("drain_data", bus.dm_data_write, 64'hDEAD_BEEF_0000_0001);
        tick();
        chk("drain_empty", 64'(bus.empty), 64'd1);
        // fill to full under continuous loads
        for (int i = 0; i < 4; i++) begin
            put(1, 12'(12'h010 + i), 64'(i), 1, 12'h100);
            tick();
        end
        chk("full_count", 64'(bus.count), 64'd4);
        put(1, 12'h014, 64'h99, 1, 12'h100);
        #1;
        chk("full_st_ready", 64'(bus.st_ready), 64'd0);
        tick();
        chk("full_5th_rejected", 64'(bus.count), 64'd4);
        wlog.delete();
        put(0, 0, 0, 0, 0);
        repeat (4) tick();
        chk("fill_writes", 64'(wlog.size()), 64'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) chk("fill_order", 64'(wlog[i].a), 64'(12'h010 + i));
        chk("fill_empty", 64'(bus.empty), 64'd1);
        // forwarding of youngest
        put(1, 12'h020, 64'h1, 1, 12'h100);
        tick();
        put(1, 12'h020, 64'h2, 1, 12'h100);
        tick();
        put(0, 0, 0, 1, 12'h020);
        #1;
        chk("fwd_data", bus.ld_data, 64'h2);
        chk("fwd_flag", 64'(bus.ld_fwd), 64'd1);
        put(0, 0, 0, 1, 12'h021);
        #1;
        chk("nofwd_flag", 64'(bus.ld_fwd), 64'd0);
        chk("nofwd_data", bus.ld_data, 64'hA5A5_0000_0000_0021);
        put(0, 0, 0, 1, 12'h005);
        #1;
        chk("mem_data", bus.ld_data, 64'hDEAD_BEEF_0000_0001);
        put(0, 0, 0, 0, 0);
        repeat (3) tick();
        // streaming stores: pointers wrap while count stays at 1
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            put(1, 12'(12'h050 + i), 64'(64'h100 + i), 0, 0);
            tick();
            chk("stream_count", 64'(bus.count), 64'd1);
        end
        put(0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("stream_writes", 64'(wlog.size()), 64'd10);
        for (int i = 0; i < 10 && i < wlog.size(); i++) begin
            chk("stream_addr", 64'(wlog[i].a), 64'(12'h050 + i));
            chk("stream_data", wlog[i].d, 64'(64'h100 + i));
        end
        // same-address stores: merged or queued twice
        put(1, 12'h030, 64'hA, 1, 12'h100);
        tick();
        put(1, 12'h030, 64'hB, 1, 12'h100);
        tick();
        wlog.delete();
        put(0, 0, 0, 0, 0);
        repeat (3) tick();
`ifdef STB_COALESCE_EN
        chk("coal_writes", 64'(wlog.size()), 64'd1);
        if (wlog.size() > 0) chk("coal_data", wlog[0].d, 64'hB);
`else
        chk("dup_writes", 64'(wlog.size()), 64'd2);
        if (wlog.size() > 1) begin
            chk("dup_first", wlog[0].d, 64'hA);
            chk("dup_second", wlog[1].d, 64'hB);
        end
`endif
        chk("end_empty", 64'(bus.empty), 64'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
